// File: rtl/q2_sequencer.sv
// Instruction-cycle sequencer for the Q2 bit-serial CPU: two-phase states, serial ALU loop, panel run/stop/step.
// Optional `define Q2_PANEL_SYNC_EN adds a 2-flop synchronizer and rising-edge detect on the panel switches.
module q2_sequencer #(
  parameter int ALU_STEPS     = 8,
  parameter bit START_RUNNING = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic deref,
  input  logic o2,
  input  logic o1,
  input  logic o0,
  input  logic run_sw,
  input  logic stop_sw,
  input  logic step_sw,
  output logic s0,
  output logic s1,
  output logic s2,
  output logic s3,
  output logic ws,
  output logic running,
  output logic halted
);

  localparam logic [3:0] ST_FETCH    = 4'b0000;
  localparam logic [3:0] ST_DEREF    = 4'b0001;
  localparam logic [3:0] ST_LOAD     = 4'b0010;
  localparam logic [3:0] ST_EXEC     = 4'b0011;
  localparam logic [3:0] ST_ALU      = 4'b0100;
  localparam logic [3:0] ST_ALU_LAST = 4'b1100;
  localparam logic [3:0] LAST_CNT    = 4'(ALU_STEPS - 2);

  logic       run_p_s, stop_p_s, step_p_s;
  logic [3:0] state_r, state_n_s;
  logic       phase_r, phase_n_s;
  logic [3:0] cnt_r, cnt_n_s;
  logic       pend_r, pend_n_s;
  logic       running_r, running_n_s;
  logic       halted_r;
  logic       step_mode_r, step_mode_n_s;
  logic       unused_op_bits_s;

  // o1/o0 select the operation inside the control decoder; sequencing never depends on them
  assign unused_op_bits_s = o1 ^ o0;

`ifdef Q2_PANEL_SYNC_EN
  logic [2:0] sw_meta_r, sw_sync_r, sw_prev_r;

  // Panel switch synchronizer and rising-edge detector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta_r <= 3'b000;
      sw_sync_r <= 3'b000;
      sw_prev_r <= 3'b000;
    end else begin
      sw_meta_r <= {run_sw, stop_sw, step_sw};
      sw_sync_r <= sw_meta_r;
      sw_prev_r <= sw_sync_r;
    end
  end

  assign {run_p_s, stop_p_s, step_p_s} = sw_sync_r & ~sw_prev_r;
`else
  assign run_p_s  = run_sw;
  assign stop_p_s = stop_sw;
  assign step_p_s = step_sw;
`endif

  // Next-state logic: state only moves on the edge ending phase 1
  always_comb begin
    state_n_s     = state_r;
    phase_n_s     = phase_r;
    cnt_n_s       = cnt_r;
    pend_n_s      = pend_r;
    running_n_s   = running_r;
    step_mode_n_s = step_mode_r;
    if (!running_r) begin
      // Halted in FETCH phase 0: stop beats run, run beats step
      pend_n_s = 1'b0;
      if (stop_p_s) begin
        running_n_s = 1'b0;
      end else if (run_p_s) begin
        running_n_s   = 1'b1;
        step_mode_n_s = 1'b0;
        phase_n_s     = 1'b1;
      end else if (step_p_s) begin
        running_n_s   = 1'b1;
        step_mode_n_s = 1'b1;
        phase_n_s     = 1'b1;
      end else begin
        running_n_s = 1'b0;
      end
    end else if (!phase_r) begin
      if ((state_r == ST_FETCH) && (pend_r || stop_p_s)) begin
        running_n_s   = 1'b0;
        pend_n_s      = 1'b0;
        step_mode_n_s = 1'b0;
      end else begin
        phase_n_s = 1'b1;
        pend_n_s  = pend_r | stop_p_s;
      end
    end else begin
      phase_n_s = 1'b0;
      pend_n_s  = pend_r | stop_p_s;
      case (state_r)
        ST_FETCH: begin
          if (deref) begin
            state_n_s = ST_DEREF;
          end else if (o2) begin
            state_n_s = ST_EXEC;
          end else begin
            state_n_s = ST_LOAD;
          end
        end
        ST_DEREF: state_n_s = o2 ? ST_EXEC : ST_LOAD;
        ST_LOAD: begin
          state_n_s = ST_ALU;
          cnt_n_s   = 4'd0;
        end
        ST_ALU: begin
          cnt_n_s   = cnt_r + 4'd1;
          state_n_s = (cnt_r < LAST_CNT) ? ST_ALU : ST_ALU_LAST;
        end
        ST_ALU_LAST: state_n_s = ST_EXEC;
        ST_EXEC: begin
          state_n_s = ST_FETCH;
          // Instruction boundary: honour a pending stop or the end of a single step
          if (pend_r || stop_p_s || step_mode_r) begin
            running_n_s   = 1'b0;
            pend_n_s      = 1'b0;
            step_mode_n_s = 1'b0;
          end else begin
            running_n_s = 1'b1;
          end
        end
        default: begin
          state_n_s = ST_FETCH;
          cnt_n_s   = 4'd0;
        end
      endcase
    end
  end

  // Sequencer registers; phase_r doubles as the glitch-free write strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_FETCH;
      phase_r     <= 1'b0;
      cnt_r       <= 4'd0;
      pend_r      <= 1'b0;
      running_r   <= START_RUNNING;
      halted_r    <= ~START_RUNNING;
      step_mode_r <= 1'b0;
    end else begin
      state_r     <= state_n_s;
      phase_r     <= phase_n_s;
      cnt_r       <= cnt_n_s;
      pend_r      <= pend_n_s;
      running_r   <= running_n_s;
      halted_r    <= ~running_n_s;
      step_mode_r <= step_mode_n_s;
    end
  end

  assign {s3, s2, s1, s0} = state_r;
  assign ws               = phase_r;
  assign running          = running_r;
  assign halted           = halted_r;

endmodule

// File: tb/tb_q2_sequencer.sv
// Directed-vector bench for q2_sequencer (ALU_STEPS=8, START_RUNNING=0); honours Q2_PANEL_SYNC_EN latency.
module tb_q2_sequencer;

`ifdef Q2_PANEL_SYNC_EN
  localparam int SW_LAT = 2;
`else
  localparam int SW_LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst, deref, o2, o1, o0, run_sw, stop_sw, step_sw;
  logic s0, s1, s2, s3, ws, running, halted;

  int n_vec = 0;
  int n_err = 0;

  q2_sequencer #(.ALU_STEPS(8), .START_RUNNING(1'b0)) dut (
    .clk(clk), .rst(rst), .deref(deref), .o2(o2), .o1(o1), .o0(o0),
    .run_sw(run_sw), .stop_sw(stop_sw), .step_sw(step_sw),
    .s0(s0), .s1(s1), .s2(s2), .s3(s3), .ws(ws),
    .running(running), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic r, input logic s, input logic t);
    run_sw = r; stop_sw = s; step_sw = t;
    tick();
    run_sw = 1'b0; stop_sw = 1'b0; step_sw = 1'b0;
    repeat (SW_LAT) tick();
  endtask

  function automatic logic [3:0] st();
    return {s3, s2, s1, s0};
  endfunction

  // Expected state at clock k of a deref ALU instruction with 8 steps
  function automatic logic [3:0] exp_alu_deref(input int k);
    int idx;
    idx = k / 2;
    if (idx == 0) return 4'b0000;
    else if (idx == 1) return 4'b0001;
    else if (idx == 2) return 4'b0010;
    else if (idx <= 9) return 4'b0100;
    else if (idx == 10) return 4'b1100;
    else return 4'b0011;
  endfunction

  initial begin
    int wsn, first, kk;
    rst = 1'b1; deref = 1'b0; o2 = 1'b0; o1 = 1'b0; o0 = 1'b0;
    run_sw = 1'b0; stop_sw = 1'b0; step_sw = 1'b0;
    #12;
    rst = 1'b0;
    check_val("reset state", {28'd0, st()}, 32'h0);
    check_val("reset ws", {31'd0, ws}, 32'h0);
    check_val("reset halted", {31'd0, halted}, 32'h1);
    check_val("reset running", {31'd0, running}, 32'h0);
    tick();

    // Single step, o2=1: 0000/0 0000/1 0011/0 0011/1 then halt
    o2 = 1'b1; o1 = 1'b1; o0 = 1'b0; deref = 1'b0;
    press(1'b0, 1'b0, 1'b1);
    check_val("step1 k1", {27'd0, halted, st()}, {27'd0, 1'b0, 4'b0000});
    check_val("step1 k1 ws", {31'd0, ws}, 32'h1);
    tick();
    check_val("step1 k2", {27'd0, ws, st()}, {27'd0, 1'b0, 4'b0011});
    tick();
    check_val("step1 k3", {27'd0, ws, st()}, {27'd0, 1'b1, 4'b0011});
    tick();
    check_val("step1 k4", {27'd0, ws, st()}, {27'd0, 1'b0, 4'b0000});
    check_val("step1 halted", {30'd0, halted, running}, {30'd0, 2'b10});

    // Single step, ALU class with deref: 24 clocks, 12 strobes
    o2 = 1'b0; deref = 1'b1;
    press(1'b0, 1'b0, 1'b1);
    wsn = 0;
    for (int k = 1; k < 24; k++) begin
      check_val($sformatf("alu k%0d", k), {27'd0, ws, st()}, {27'd0, 1'(k % 2), exp_alu_deref(k)});
      if (ws) wsn++;
      tick();
    end
    check_val("alu end", {26'd0, halted, ws, st()}, {26'd0, 2'b10, 4'b0000});
    check_val("alu ws count", wsn, 32'd11 + 32'd1);

    // Run, stop during 2nd instruction's ALU loop (22-clock instructions)
    deref = 1'b0; o2 = 1'b0;
    press(1'b1, 1'b0, 1'b0);
    wsn = 0; first = 0;
    for (int k = 1; k <= 50; k++) begin
      if (ws) wsn++;
      if (halted && first == 0) first = k;
      stop_sw = (k == 30);
      tick();
    end
    stop_sw = 1'b0;
    check_val("stop halt clock", first, 32'd44);
    check_val("stop ws count", wsn, 32'd22);

    // Async reset during LOAD phase 1
    press(1'b0, 1'b0, 1'b1);
    tick(); tick();
    check_val("pre-rst load ph1", {27'd0, ws, st()}, {27'd0, 1'b1, 4'b0010});
    rst = 1'b1;
    #1;
    check_val("async rst", {26'd0, halted, ws, st()}, {26'd0, 2'b10, 4'b0000});
    check_val("async rst running", {31'd0, running}, 32'h0);
    #1;
    rst = 1'b0;
    tick();
    check_val("post-rst idle", {26'd0, halted, ws, st()}, {26'd0, 2'b10, 4'b0000});
    press(1'b0, 1'b0, 1'b1);
    wsn = 0; first = 0;
    for (int k = 1; k <= 40; k++) begin
      if (ws) wsn++;
      if (halted && first == 0) first = k;
      tick();
    end
    check_val("post-rst alu len", first, 32'd22);
    check_val("post-rst ws count", wsn, 32'd11);

    // run+stop together while halted: stop wins
    press(1'b1, 1'b1, 1'b0);
    wsn = 0; first = 0;
    for (int k = 0; k < 10; k++) begin
      if (ws) wsn++;
      if (!halted) first++;
      tick();
    end
    check_val("run+stop ws", wsn, 32'd0);
    check_val("run+stop not halted", first, 32'd0);

    // step+run together: run wins, keeps going past one instruction
    o2 = 1'b1; deref = 1'b0;
    press(1'b1, 1'b0, 1'b1);
    tick(); tick(); tick();
    check_val("step+run k4", {26'd0, running, ws, st()}, {26'd0, 2'b10, 4'b0000});
    tick();
    check_val("step+run k5", {26'd0, halted, ws, st()}, {26'd0, 2'b01, 4'b0000});
    press(1'b0, 1'b1, 1'b0);
    kk = 6 + SW_LAT; first = 0;
    for (int k = 0; k < 20 && first == 0; k++) begin
      if (halted) first = kk;
      else begin
        kk++;
        tick();
      end
    end
    check_val("step+run stop clock", first, 32'd8);
    wsn = 0;
    for (int k = 0; k < 8; k++) begin
      if (ws) wsn++;
      tick();
    end
    check_val("after stop ws", wsn, 32'd0);

`ifdef Q2_PANEL_SYNC_EN
    // Held step switch acts as one press, delayed by the synchronizer
    step_sw = 1'b1;
    wsn = 0; first = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (ws) begin
        wsn++;
        if (first == 0) first = k;
      end
      if (k == 50) step_sw = 1'b0;
    end
    check_val("held step ws", wsn, 32'd2);
    check_val("held step start", first, 32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/q2_sequencer.md
Name: q2_sequencer

Overview:
- Instruction-cycle sequencer for the Q2 bit-serial CPU.
- Generates the state bits s0..s3 and the write strobe ws consumed by the control decoder.
- Walks each instruction through FETCH, optional DEREF, LOAD, an N-step serial ALU loop, and EXEC.
- Owns front-panel run, stop and single-step control.

Parameters:
- ALU_STEPS, 8, number of serial ALU shift steps per ALU instruction (2..15).
- START_RUNNING, 0, 1 = sequencer leaves reset in the running state.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active high
- deref  in  1  current instruction uses indirect addressing
- o2  in  1  opcode bit 2 (0 = ALU class)
- o1  in  1  opcode bit 1
- o0  in  1  opcode bit 0
- run_sw  in  1  start continuous execution (pulse)
- stop_sw  in  1  stop at next instruction boundary (pulse)
- step_sw  in  1  execute exactly one instruction (pulse)
- s0  out  1  state bit 0
- s1  out  1  state bit 1
- s2  out  1  state bit 2
- s3  out  1  state bit 3
- ws  out  1  write strobe; high only in phase 1 of an active state
- running  out  1  sequencer is executing instructions
- halted  out  1  idle in FETCH phase 0; panel deposit is permitted

Behaviour:
- State encoding {s3,s2,s1,s0}:
  - FETCH = 0000, DEREF = 0001, LOAD = 0010, EXEC = 0011.
  - ALU = 0100; the last ALU step is 1100.
- Two-phase states: every state lasts 2 clocks.
  - Phase 0: ws=0.
  - Phase 1: ws=1.
  - The state advances on the clock edge that ends phase 1.
- Transitions at the end of phase 1:
  - FETCH -> DEREF if deref; else LOAD if o2=0; else EXEC.
  - DEREF -> LOAD if o2=0; else EXEC.
  - LOAD -> ALU with step counter = 0.
  - ALU -> ALU with counter+1 while counter < ALU_STEPS-2. In that ALU step s3=0.
  - When counter = ALU_STEPS-2 the next step is the last one (s3=1). After it, go to EXEC.
  - EXEC -> FETCH.
- Opcode and deref are sampled each phase 1. They are stable from FETCH phase 1 onward.
- Instruction length in clocks:
  - o2=1: 4 clocks, or 6 with deref.
  - o2=0: 6 + 2*ALU_STEPS clocks, plus 2 with deref.
- Run control:
  - When halted, the sequencer holds FETCH phase 0: ws=0, halted=1, running=0.
  - run_sw while halted: running=1, and the next clock enters FETCH phase 1.
  - stop_sw while running sets a pending-stop flag. The current instruction completes. On return to FETCH, the sequencer halts before phase 1.
  - step_sw while halted runs one instruction, then halts in FETCH phase 0. running=1 for the duration.
  - run_sw or step_sw while running: ignored.
  - stop_sw while halted: ignored.
  - stop_sw and run_sw in the same cycle while halted: stop wins; stay halted.
  - step_sw and run_sw together while halted: run wins.
- ALU step counter: 4 bits. It cannot wrap because ALU_STEPS is at most 15. It is cleared on LOAD exit and on reset.
- Reset (asynchronous):
  - State FETCH, phase 0, counter 0, pending-stop 0, ws=0, s3..s0=0000.
  - START_RUNNING=0: halted=1, running=0.
  - START_RUNNING=1: running=1, halted=0.
  - Reset asserted mid-instruction abandons the instruction immediately. No partial ws pulse is generated after the reset edge.
- ws is registered (glitch-free) and never high for two consecutive clocks.

Optional Feature:
- Macro: Q2_PANEL_SYNC_EN.
- Defined:
  - run_sw, stop_sw and step_sw each pass through a 2-flop synchronizer plus rising-edge detect.
  - Held switches therefore act as a single press.
  - This adds 2 clocks of input latency.
  - Synchronizer flops reset to 0.
- Undefined: the switches are treated as synchronous single-cycle pulses, used directly.

Test Plan:
- Reset with START_RUNNING=0, then pulse step_sw with o2=1, o1=1, o0=0, deref=0.
  - Required: states 0000,0000,0011,0011, then halt in 0000.
  - ws pattern 0,1,0,1; halted returns to 1 after 4 clocks.
- step_sw with o2=0, deref=1, ALU_STEPS=8.
  - Required: sequence FETCH, DEREF, LOAD, 7 ALU steps (0100), 1 ALU step (1100), EXEC.
  - Total 24 clocks; exactly 12 ws pulses.
- run_sw, then stop_sw asserted during the ALU loop of the 2nd instruction.
  - Required: the 2nd instruction completes through EXEC, then halts in FETCH phase 0. No 3rd FETCH ws pulse.
- rst asserted during LOAD phase 1.
  - Required: s3..s0=0000 and ws=0 immediately (asynchronous). Counter is 0 after release. halted=1.
- run_sw and stop_sw in the same cycle while halted.
  - Required: remains halted and ws stays 0 for 10 clocks.
- With Q2_PANEL_SYNC_EN defined, hold step_sw high for 50 clocks (o2=1).
  - Required: exactly one instruction executes (2 ws pulses). Its start is delayed 2 clocks versus the non-sync build.
